// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the iterative divider.
//   divStateT  - FSM state encoding (IDLE, BUSY, DONE)
//   DIV_CYCLES - iteration count of a full 32-bit divide
package div_pkg;

    localparam int unsigned DIV_CYCLES = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } divStateT;

endpackage

// File: rtl/div_if.sv
// div_if: execute-stage <-> divider handshake.
//   master (pipeline): drives divE, signedE, srcaE, srcbE, cancelE
//   slave  (divider):  drives divstallE, divdoneE, loE, hiE
interface div_if #(
    parameter int unsigned WIDTH = 32
);
    logic             divE;
    logic             signedE;
    logic [WIDTH-1:0] srcaE;
    logic [WIDTH-1:0] srcbE;
    logic             cancelE;
    logic             divstallE;
    logic             divdoneE;
    logic [WIDTH-1:0] loE;
    logic [WIDTH-1:0] hiE;

    modport master (
        output divE, signedE, srcaE, srcbE, cancelE,
        input  divstallE, divdoneE, loE, hiE
    );

    modport slave (
        input  divE, signedE, srcaE, srcbE, cancelE,
        output divstallE, divdoneE, loE, hiE
    );
endinterface

// File: rtl/div_datapath.sv
// div_datapath: restoring-divide shift registers, trial subtractor and
// sign correction of the final quotient/remainder.
//   clk, rst     - clock, synchronous active-high reset
//   start        - latch operand magnitudes and signs, clear remainder
//   bypass       - zero-divisor shortcut: write results at the start edge
//   step         - perform one shift/subtract iteration
//   finish       - this step is the last one; register corrected results
//   signedIn     - signed divide
//   srcA, srcB   - dividend, divisor
//   lo, hi       - registered quotient, remainder
module div_datapath #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bypass,
    input  logic             step,
    input  logic             finish,
    input  logic             signedIn,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    logic [WIDTH-1:0] rem, quo, divisor;
    logic             quoSign, remSign;

    logic             aNeg, bNeg;
    logic [WIDTH-1:0] absA, absB;
    logic [WIDTH:0]   remSh;
    logic             geq;
    logic [WIDTH-1:0] remDiff, remNext, quoNext;

    function automatic logic [WIDTH-1:0] fixSign(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    // Operand magnitudes; 0x80000000 maps onto itself as an unsigned magnitude.
    assign aNeg = signedIn & srcA[WIDTH-1];
    assign bNeg = signedIn & srcB[WIDTH-1];
    assign absA = fixSign(srcA, aNeg);
    assign absB = fixSign(srcB, bNeg);

    // One iteration: remSh < 2*divisor, so a W-bit difference suffices when geq.
    assign remSh   = {rem, quo[WIDTH-1]};
    assign geq     = remSh >= {1'b0, divisor};
    assign remDiff = remSh[WIDTH-1:0] - divisor;
    assign remNext = geq ? remDiff : remSh[WIDTH-1:0];
    assign quoNext = {quo[WIDTH-2:0], geq};

    always_ff @(posedge clk) begin
        if (rst) begin
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            quoSign <= 1'b0;
            remSign <= 1'b0;
            lo      <= '0;
            hi      <= '0;
        end else if (start) begin
            rem     <= '0;
            quo     <= absA;
            divisor <= absB;
            quoSign <= aNeg ^ bNeg;
            remSign <= aNeg;
            if (bypass) begin
                lo <= fixSign({WIDTH{1'b1}}, aNeg ^ bNeg);
                hi <= fixSign(absA, aNeg);
            end
        end else if (step) begin
            rem <= remNext;
            quo <= quoNext;
            if (finish) begin
                lo <= fixSign(quoNext, quoSign);
                hi <= fixSign(remNext, remSign);
            end
        end
    end

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU in execute.
// Holds the pipeline via divstallE and pulses divdoneE with LO/HI.
//   clk, rst - clock, synchronous active-high reset
//   bus      - div_if.slave (divE, signedE, srcaE, srcbE, cancelE in;
//              divstallE, divdoneE, loE, hiE out)
// Build option: DIV_ZERO_BYPASS_EN - zero divisor skips the iterations.
module div_unit
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_CYCLES
) (
    input  logic clk,
    input  logic rst,
    div_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    divStateT          state;
    logic [CNT_W-1:0]  count;
    logic              doneQ;
    logic              start, step, last, bypass;
    logic [WIDTH-1:0]  lo, hi;

    assign start = (state == IDLE) & bus.divE & ~bus.cancelE;
    assign step  = (state == BUSY) & ~bus.cancelE;
    assign last  = count == CNT_W'(WIDTH - 1);

`ifdef DIV_ZERO_BYPASS_EN
    assign bypass = start & (bus.srcbE == '0);
`else
    assign bypass = 1'b0;
`endif

    // State, iteration counter and registered done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            doneQ <= 1'b0;
        end else begin
            doneQ <= 1'b0;
            if (bus.cancelE) begin
                state <= IDLE;
                count <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.divE) begin
                            count <= '0;
                            if (bypass) begin
                                state <= DONE;
                                doneQ <= 1'b1;
                            end else begin
                                state <= BUSY;
                            end
                        end
                    end
                    BUSY: begin
                        count <= count + CNT_W'(1);
                        if (last) begin
                            state <= DONE;
                            doneQ <= 1'b1;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    div_datapath #(.WIDTH(WIDTH)) uDatapath (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bypass   (bypass),
        .step     (step),
        .finish   (step & last),
        .signedIn (bus.signedE),
        .srcA     (bus.srcaE),
        .srcB     (bus.srcbE),
        .lo       (lo),
        .hi       (hi)
    );

    // Stall covers the start cycle combinationally, then all of BUSY.
    assign bus.divstallE = ~rst & (start | (state == BUSY));
    assign bus.divdoneE  = doneQ;
    assign bus.loE       = lo;
    assign bus.hiE       = hi;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit.
module tb_div_unit;
    import div_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   failures = 0;
    int   cyc = 0;
    int   doneA, doneB, pulses;

`ifdef DIV_ZERO_BYPASS_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif

    div_if #(.WIDTH(32)) bus ();

    div_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one divide, hold divE until divdoneE, check latency, stall count and results.
    task automatic doDiv(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expLo,
                         input logic [31:0] expHi, input int expLat, output int doneAt);
        int stalls;
        int doneC;
        logic stallAtDone;
        stalls = 0;
        doneC = -1;
        stallAtDone = 1'b1;
        @(negedge clk);
        bus.divE    = 1'b1;
        bus.signedE = sgn;
        bus.srcaE   = a;
        bus.srcbE   = b;
        for (int c = 0; c < 200; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (bus.divdoneE) begin
                doneC = c;
                stallAtDone = bus.divstallE;
                break;
            end
            if (bus.divstallE) stalls++;
        end
        bus.divE = 1'b0;
        doneAt = cyc;
        checkEq({tag, "-latency"}, 32'(doneC), 32'(expLat));
        checkEq({tag, "-stalls"}, 32'(stalls), 32'(expLat));
        checkEq({tag, "-stallAtDone"}, {31'd0, stallAtDone}, 32'd0);
        checkEq({tag, "-lo"}, bus.loE, expLo);
        checkEq({tag, "-hi"}, bus.hiE, expHi);
    endtask

    initial begin
        bus.divE    = 1'b1;
        bus.signedE = 1'b0;
        bus.srcaE   = 32'd100;
        bus.srcbE   = 32'd7;
        bus.cancelE = 1'b0;

        // Reset: stall suppressed even with divE high.
        repeat (3) @(negedge clk);
        #1;
        checkEq("rst-stall", {31'd0, bus.divstallE}, 32'd0);
        checkEq("rst-done", {31'd0, bus.divdoneE}, 32'd0);
        checkEq("rst-lo", bus.loE, 32'd0);
        checkEq("rst-hi", bus.hiE, 32'd0);
        bus.divE = 1'b0;
        rst = 1'b0;

        doDiv("divu100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, doneA);
        @(negedge clk);
        #1;
        checkEq("pulse-once", {31'd0, bus.divdoneE}, 32'd0);
        checkEq("stable-lo", bus.loE, 32'd14);

        doDiv("div-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, doneA);
        doDiv("div-100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 33, doneA);
        doDiv("div-ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33, doneA);
        doDiv("divu5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, ZLAT, doneA);
        doDiv("div-5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'd1, 32'hFFFF_FFFB, ZLAT, doneA);

        // Cancel in BUSY cycle 10; results stay at the previous values (1, -5).
        @(negedge clk);
        bus.divE    = 1'b1;
        bus.signedE = 1'b0;
        bus.srcaE   = 32'd1000;
        bus.srcbE   = 32'd3;
        for (int c = 0; c <= 10; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 10) bus.cancelE = 1'b1;
            #1;
        end
        @(negedge clk);
        bus.cancelE = 1'b0;
        bus.divE    = 1'b0;
        #1;
        checkEq("cancel-stall", {31'd0, bus.divstallE}, 32'd0);
        checkEq("cancel-done", {31'd0, bus.divdoneE}, 32'd0);
        checkEq("cancel-lo", bus.loE, 32'd1);
        checkEq("cancel-hi", bus.hiE, 32'hFFFF_FFFB);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (bus.divdoneE || bus.divstallE) pulses++;
        end
        checkEq("cancel-quiet", 32'(pulses), 32'd0);
        doDiv("divu9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33, doneA);

        // Back-to-back divides.
        doDiv("divu20_6", 1'b0, 32'd20, 32'd6, 32'd3, 32'd2, 33, doneA);
        doDiv("div20_-6", 1'b1, 32'd20, 32'hFFFF_FFFA, 32'hFFFF_FFFD, 32'd2, 33, doneB);
        checkEq("b2b-gap", 32'(doneB - doneA), 32'd34);

        // Reset mid-BUSY clears everything on the next edge.
        @(negedge clk);
        bus.divE    = 1'b1;
        bus.signedE = 1'b0;
        bus.srcaE   = 32'd77;
        bus.srcbE   = 32'd5;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checkEq("midrst-stall", {31'd0, bus.divstallE}, 32'd0);
        checkEq("midrst-done", {31'd0, bus.divdoneE}, 32'd0);
        checkEq("midrst-lo", bus.loE, 32'd0);
        checkEq("midrst-hi", bus.hiE, 32'd0);
        rst = 1'b0;
        bus.divE = 1'b0;
        @(negedge clk);
        #1;
        checkEq("postrst-stall", {31'd0, bus.divstallE}, 32'd0);
        doDiv("postrst77_5", 1'b0, 32'd77, 32'd5, 32'd15, 32'd2, 33, doneA);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
